// File: rtl/alu4_pkg.sv
// alu4_pkg: shared constants and types for the adder4 built-in self-test.
//   DATA_W  - operand width of the ALU under test
//   VEC_W   - width of the sweep index {opt,a,b}
//   NUM_VEC - number of vectors in one sweep
//   ERR_W   - width of the mismatch counter (must hold NUM_VEC)
//   state_e - self-test FSM states
//   resp_t  - the 7-bit ALU response {carry,zero,overflow,y}
package alu4_pkg;

  localparam int DATA_W  = 4;
  localparam int VEC_W   = 9;
  localparam int NUM_VEC = 512;
  localparam int ERR_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              carry;
    logic              zero;
    logic              overflow;
    logic [DATA_W-1:0] y;
  } resp_t;

endpackage

// File: rtl/alu4_selftest_golden.sv
// alu4_golden: combinational reference model of the 4-bit adder/subtractor.
// Ports:
//   a, b - operands
//   opt  - 0 = add, 1 = subtract
//   resp - expected {carry,zero,overflow,y}
module alu4_golden
  import alu4_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              opt,
  output resp_t             resp
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  // Subtraction is a + ~b + 1, so carry out is the inverted borrow.
  assign b_op = opt ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, opt};

  always_comb begin
    resp.y     = sum[DATA_W-1:0];
    resp.carry = sum[DATA_W];
    resp.zero  = (sum[DATA_W-1:0] == '0);
    // Signed overflow: effective operands share a sign, result sign differs.
    // Using the inverted b for subtract covers both opcodes in one term.
    resp.overflow = (a[DATA_W-1] == b_op[DATA_W-1]) &&
                    (sum[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/alu4_selftest.sv
// alu4_selftest: built-in self-test engine for the adder4 ALU.
// On start it sweeps all {opt,a,b} vectors (b fastest, opt slowest), holds
// each for SETTLE_CYCLES cycles, compares the ALU response against the
// golden model and records the error count and first failing vector.
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (>=1)
//   STOP_ON_FAIL  - 1 ends the sweep at the first mismatch
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   start                         - begin a sweep (ignored while busy)
//   a, b, opt                     - stimulus to the ALU
//   y, carry, zero, overflow      - ALU response
//   busy, done, pass              - sweep status
//   err_count, first_fail_vec     - error bookkeeping
module alu4_selftest
  import alu4_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              opt,
  input  logic [DATA_W-1:0] y,
  input  logic              carry,
  input  logic              zero,
  input  logic              overflow,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [VEC_W-1:0]  first_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [VEC_W-1:0]  ff_q, ff_d;
  logic              pass_q, pass_d;

  resp_t             gold_resp;
  resp_t             dut_resp;
  logic              mismatch;
  logic              last_vec;

  alu4_golden u_golden (
    .a    (vec_q[2*DATA_W-1:DATA_W]),
    .b    (vec_q[DATA_W-1:0]),
    .opt  (vec_q[VEC_W-1]),
    .resp (gold_resp)
  );

  assign dut_resp = {carry, zero, overflow, y};
  assign mismatch = (dut_resp != gold_resp);
  assign last_vec = (vec_q == LAST_VEC) || ((STOP_ON_FAIL != 0) && mismatch);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          vec_d    = '0;
          settle_d = SETTLE_LOAD;
          err_d    = '0;
          ff_d     = '0;
          pass_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (settle_q != '0) begin
          settle_d = settle_q - CNT_W'(1);
        end else begin
          // Last held cycle of this vector: the response has settled.
          if (mismatch) begin
            err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              ff_d = vec_q;
            end
          end
          if (last_vec) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end else begin
            vec_d    = vec_q + VEC_W'(1);
            settle_d = SETTLE_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      pass_q   <= pass_d;
    end
  end

  assign a              = vec_q[2*DATA_W-1:DATA_W];
  assign b              = vec_q[DATA_W-1:0];
  assign opt            = vec_q[VEC_W-1];
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ff_q;

endmodule
